// File: rtl/enoc_switch_allocator_if.sv
// Allocator request/grant bundle: requests and enables in, grants and selects out.
interface enoc_switch_allocator_if #(
    parameter int N = 7,
    parameter int M = 7
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [0:N-1][0:M-1]  i_req;
    logic [0:M-1]         i_en;
    logic [0:N-1][0:M-1]  o_grant;
    logic [0:M-1][W-1:0]  o_sel;
    logic [0:M-1]         o_sel_val;

    modport master (
        output i_req, i_en,
        input  o_grant, o_sel, o_sel_val
    );

    modport slave (
        input  i_req, i_en,
        output o_grant, o_sel, o_sel_val
    );
endinterface

// File: rtl/enoc_switch_allocator.sv
// Per-output round-robin switch allocator with registered grants.
// Define ENOC_ALLOC_HOLD_EN to build multi-cycle grant tenures (HOLD_MAX cycles).
module enoc_switch_allocator #(
    parameter int N        = 7,
    parameter int M        = 7,
    parameter int HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    enoc_switch_allocator_if.slave bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    typedef logic [W-1:0] idx_t;

    if (HOLD_MAX < 1) begin : g_hold_max_chk
        $error("HOLD_MAX must be at least 1");
    end

    function automatic idx_t next_idx(idx_t v);
        return (v == idx_t'(N - 1)) ? '0 : v + idx_t'(1);
    endfunction

    logic                 live_q;
    logic [0:N-1][0:M-1]  grant_q, grant_d;
    logic [0:M-1]         val_q, val_d;
    idx_t [0:M-1]         sel_q, sel_d;
    idx_t [0:M-1]         ptr_q, ptr_d;
    logic [0:N-1][0:M-1]  req_eff;
    logic [0:M-1]         found;
    idx_t [0:M-1]         win;

`ifdef ENOC_ALLOC_HOLD_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    typedef enum logic {S_IDLE, S_HOLD} st_t;
    st_t           st_q  [M];
    st_t           st_d  [M];
    logic [CW-1:0] cnt_q [M];
    logic [CW-1:0] cnt_d [M];

    assign req_eff = bus.i_req;
`else
    // A request that was just granted is consumed for one cycle.
    assign req_eff = bus.i_req & ~grant_q;
`endif

    always_comb begin
        found = '0;
        win   = '0;
        for (int j = 0; j < M; j++) begin
            for (int k = 0; k < N; k++) begin
                if (!found[j] &&
                    req_eff[idx_t'((int'(ptr_q[j]) + k) % N)][j]) begin
                    found[j] = 1'b1;
                    win[j]   = idx_t'((int'(ptr_q[j]) + k) % N);
                end
            end
        end
    end

    always_comb begin
        grant_d = '0;
        val_d   = '0;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ENOC_ALLOC_HOLD_EN
        st_d    = st_q;
        cnt_d   = cnt_q;
`endif
        for (int j = 0; j < M; j++) begin
`ifdef ENOC_ALLOC_HOLD_EN
            unique case (st_q[j])
                S_IDLE: begin
                    if (live_q && bus.i_en[j] && found[j]) begin
                        grant_d[win[j]][j] = 1'b1;
                        val_d[j]           = 1'b1;
                        sel_d[j]           = win[j];
                        st_d[j]            = S_HOLD;
                        cnt_d[j]           = CW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.i_req[sel_q[j]][j] && bus.i_en[j] &&
                        cnt_q[j] < CW'(HOLD_MAX)) begin
                        grant_d[sel_q[j]][j] = 1'b1;
                        val_d[j]             = 1'b1;
                        cnt_d[j]             = cnt_q[j] + CW'(1);
                    end else begin
                        st_d[j]  = S_IDLE;
                        cnt_d[j] = '0;
                        ptr_d[j] = next_idx(sel_q[j]);
                    end
                end
                default: st_d[j] = S_IDLE;
            endcase
`else
            if (live_q && bus.i_en[j] && found[j]) begin
                grant_d[win[j]][j] = 1'b1;
                val_d[j]           = 1'b1;
                sel_d[j]           = win[j];
                ptr_d[j]           = next_idx(win[j]);
            end
`endif
        end
    end

    // live_q blocks arbitration on the first edge after reset release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            live_q  <= 1'b0;
            grant_q <= '0;
            val_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
`ifdef ENOC_ALLOC_HOLD_EN
            for (int j = 0; j < M; j++) begin
                st_q[j]  <= S_IDLE;
                cnt_q[j] <= '0;
            end
`endif
        end else begin
            live_q  <= 1'b1;
            grant_q <= grant_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ENOC_ALLOC_HOLD_EN
            for (int j = 0; j < M; j++) begin
                st_q[j]  <= st_d[j];
                cnt_q[j] <= cnt_d[j];
            end
`endif
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_sel_val = val_q;
    assign bus.o_sel     = sel_q;
endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Randomized bench for enoc_switch_allocator against a per-output reference model.
// Directed sequences pin the model with literal expected winners.
module tb_enoc_switch_allocator;
    localparam int N  = 7;
    localparam int M  = 7;
    localparam int HM = 4;
    localparam int W  = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    enoc_switch_allocator_if #(.N(N), .M(M)) bus ();

    enoc_switch_allocator #(.N(N), .M(M), .HOLD_MAX(HM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: current grantee per output (-1 none), select, pointer, tenure length.
    int m_gnt [M];
    int m_sel [M];
    int m_ptr [M];
    int m_cnt [M];
    int m_rel;

    function automatic logic rq(int i, int j);
        return bus.i_req[W'(i)][W'(j)];
    endfunction

    function automatic int pick(int j, int skip);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr[j] + k) % N;
            if (rq(i, j) && i != skip) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int nxt [M];
        if (!reset_n) begin
            for (int j = 0; j < M; j++) begin
                m_gnt[j] = -1;
                m_sel[j] = 0;
                m_ptr[j] = 0;
                m_cnt[j] = 0;
            end
            m_rel = 0;
        end else begin
            for (int j = 0; j < M; j++) begin
                nxt[j] = -1;
`ifdef ENOC_ALLOC_HOLD_EN
                if (m_gnt[j] >= 0) begin
                    if (rq(m_gnt[j], j) && bus.i_en[W'(j)] && m_cnt[j] < HM) begin
                        nxt[j] = m_gnt[j];
                        m_cnt[j]++;
                    end else begin
                        m_ptr[j] = (m_gnt[j] + 1) % N;
                        m_cnt[j] = 0;
                    end
                end else if (m_rel > 0 && bus.i_en[W'(j)]) begin
                    nxt[j] = pick(j, -1);
                    if (nxt[j] >= 0) begin
                        m_cnt[j] = 1;
                        m_sel[j] = nxt[j];
                    end
                end
`else
                if (m_rel > 0 && bus.i_en[W'(j)]) begin
                    nxt[j] = pick(j, m_gnt[j]);
                    if (nxt[j] >= 0) begin
                        m_ptr[j] = (nxt[j] + 1) % N;
                        m_sel[j] = nxt[j];
                    end
                end
`endif
                m_gnt[j] = nxt[j];
            end
            m_rel++;
        end
        #1;
        for (int j = 0; j < M; j++) begin
            logic [0:N-1] col;
            logic [0:N-1] want;
            for (int i = 0; i < N; i++) begin
                col[W'(i)]  = bus.o_grant[W'(i)][W'(j)];
                want[W'(i)] = (m_gnt[j] == i);
            end
            total++;
            if (col !== want) begin
                bad++;
                $display("FAIL grant t=%0t col %0d got %b want %b", $time, j, col, want);
            end
            total++;
            if (bus.o_sel_val[W'(j)] !== (m_gnt[j] >= 0)) begin
                bad++;
                $display("FAIL sel_val t=%0t col %0d got %b want %b",
                         $time, j, bus.o_sel_val[W'(j)], (m_gnt[j] >= 0));
            end
            total++;
            if (int'(bus.o_sel[W'(j)]) != m_sel[j]) begin
                bad++;
                $display("FAIL sel t=%0t col %0d got %0d want %0d",
                         $time, j, bus.o_sel[W'(j)], m_sel[j]);
            end
        end
    end

    task automatic lit_col(string nm, int j, int exp);
        int got = -1;
        int n   = 0;
        for (int i = 0; i < N; i++)
            if (bus.o_grant[W'(i)][W'(j)]) begin
                got = i;
                n++;
            end
        total++;
        if (n > 1 || got != exp || bus.o_sel_val[W'(j)] !== (exp >= 0) ||
            (exp >= 0 && int'(bus.o_sel[W'(j)]) != exp)) begin
            bad++;
            $display("FAIL %s: col %0d got row %0d (n=%0d) sel %0d, want row %0d",
                     nm, j, got, n, bus.o_sel[W'(j)], exp);
        end
    endtask

    task automatic step_chk(string nm, int j, int exp);
        @(posedge clk);
        #2;
        lit_col(nm, j, exp);
    endtask

    task automatic lit_zero(string nm);
        total++;
        if (bus.o_grant !== '0 || bus.o_sel_val !== '0 || bus.o_sel !== '0) begin
            bad++;
            $display("FAIL %s: grant %h val %b sel %h, want all zero",
                     nm, bus.o_grant, bus.o_sel_val, bus.o_sel);
        end
    endtask

    task automatic setr(int i, int j, logic v);
        bus.i_req[W'(i)][W'(j)] = v;
    endtask

    task automatic idle(int n);
        bus.i_req = '0;
        bus.i_en  = '1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.i_req = '0;
        bus.i_en  = '1;
        repeat (3) @(negedge clk);
        lit_zero("reset");

        reset_n = 1'b1;
        setr(0, 0, 1'b1);
        step_chk("first_edge", 0, -1);
        step_chk("second_edge", 0, 0);
        @(negedge clk);
        idle(3);

`ifdef ENOC_ALLOC_HOLD_EN
        setr(2, 1, 1'b1);
        setr(5, 1, 1'b1);
        for (int c = 0; c < 9; c++)
            step_chk("hold", 1, (c < 4) ? 2 : (c == 4) ? -1 : 5);
        @(negedge clk);
        idle(3);
`else
        setr(1, 2, 1'b1);
        setr(3, 2, 1'b1);
        setr(5, 2, 1'b1);
        for (int c = 0; c < 6; c++)
            step_chk("rr135", 2, (c % 3) * 2 + 1);
        @(negedge clk);
        idle(3);

        setr(5, 3, 1'b1);
        step_chk("ptr_set", 3, 5);
        @(negedge clk);
        setr(5, 3, 1'b0);
        setr(6, 3, 1'b1);
        setr(0, 3, 1'b1);
        step_chk("wrap6", 3, 6);
        step_chk("wrap0", 3, 0);
        @(negedge clk);
        setr(6, 3, 1'b0);
        setr(1, 3, 1'b1);
        step_chk("ptr_is_1", 3, 1);
        @(negedge clk);
        idle(3);
`endif

        bus.i_en[0] = 1'b0;
        setr(4, 0, 1'b1);
        for (int c = 0; c < 5; c++) step_chk("en_low", 0, -1);
        @(negedge clk);
        bus.i_en[0] = 1'b1;
        step_chk("en_high", 0, 4);
        @(negedge clk);
        idle(4);

        for (int i = 0; i < N; i++) setr(i, (i + 2) % M, 1'b1);
        @(posedge clk);
        #2;
        for (int j = 0; j < M; j++) lit_col("all7", j, (j + M - 2) % M);
        @(negedge clk);
        idle(4);

        setr(2, 4, 1'b1);
        setr(5, 4, 1'b1);
        step_chk("pre_rst", 4, 5);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        lit_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step_chk("post_rst1", 4, -1);
        step_chk("post_rst2", 4, 2);
        @(negedge clk);
        idle(3);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 40) begin
                    int r;
                    r = int'($urandom_range(0, M + 2));
                    for (int j = 0; j < M; j++) setr(i, j, (j == r));
                end
            end
            for (int j = 0; j < M; j++)
                bus.i_en[W'(j)] = ($urandom_range(0, 99) < 80);
            reset_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enoc_switch_allocator.md
ENOC_SWITCH_ALLOCATOR -- requirements
Module: enoc_switch_allocator

Interface
REQ-001 SHALL have parameter N, default 7, number of router input ports (requesters).
REQ-002 SHALL have parameter M, default 7, number of router output ports (resources).
REQ-003 SHALL have parameter HOLD_MAX, default 4, maximum consecutive grant cycles per tenure; only used with ENOC_ALLOC_HOLD_EN.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_req  input  [0:N-1][0:M-1]  request from input i for output j; at most one bit set per input i (one-hot or zero).
REQ-007 SHALL have port i_en  input  [0:M-1]  downstream enable of output j; a grant on j is only issued while it is high.
REQ-008 SHALL have port o_grant  output  [0:N-1][0:M-1]  registered grant; input i may transfer to output j in a cycle where the bit is high.
REQ-009 SHALL have port o_sel  output  [0:M-1][$clog2(N)-1:0]  crossbar select: index of the input granted on output j.
REQ-010 SHALL have port o_sel_val  output  [0:M-1]  high when output j has an active grant; equals OR of column j of o_grant.

Function
REQ-011 SHALL run one independent arbiter per output j, each with a round-robin pointer ptr[j] of $clog2(N) bits.
REQ-012 SHALL, for each output in state IDLE with i_en[j]=1, select as winner the first i with i_req[i][j]=1, searching ptr[j], ptr[j]+1, ... wrapping from N-1 to 0.
REQ-013 SHALL register the decision: o_grant[winner][j], o_sel[j]=winner and o_sel_val[j] are high in the cycle after the request is sampled (latency 1).
REQ-014 SHALL set ptr[j] to (winner+1) mod N when the tenure ends, with N-1 wrapping to 0.
REQ-015 SHALL never assert more than one o_grant bit per column j, nor per row i.
REQ-016 SHALL, without hold mode, keep grants single-cycle: the tenure ends in the cycle the grant is asserted, and in that cycle i_req[winner][j] is masked out of arbitration for j (consumed request).
REQ-017 SHALL allow back-to-back single-cycle grants on one output to different inputs with no bubble.
REQ-018 SHALL issue no grant on j while i_en[j]=0 in the sampling cycle; ptr[j] unchanged.
REQ-019 SHALL hold o_sel[j] at its last value when o_sel_val[j]=0.
REQ-020 SHALL ignore requests on outputs with no requesters; no grant, ptr unchanged.

Reset
REQ-021 SHALL, when reset_n=0 at a rising edge, clear o_grant, o_sel_val and o_sel to 0, all ptr[j] to 0, all FSMs to IDLE, all hold counters to 0.
REQ-022 SHALL, when reset is asserted mid-tenure, drop all grants the following cycle with no further transfer granted.
REQ-023 SHALL issue the first grant no earlier than the second rising edge after reset_n returns to 1.

Configuration
REQ-024 SHALL compile grant hold mode in only when macro ENOC_ALLOC_HOLD_EN is defined.
REQ-025 SHALL, with ENOC_ALLOC_HOLD_EN, use per-output FSM IDLE->HOLD on a win (counter=1); in HOLD stay and increment while i_req[winner][j]=1, i_en[j]=1 and counter<HOLD_MAX; otherwise go to IDLE, deassert the grant, advance ptr per REQ-014.
REQ-026 SHALL, with ENOC_ALLOC_HOLD_EN, insert exactly one grant-free cycle on j after each tenure ends (leaving HOLD), and shall not apply the masking of REQ-016.
REQ-027 SHALL, without ENOC_ALLOC_HOLD_EN, contain no hold counter or HOLD state, and behave per REQ-016.

Verification
REQ-028 SHALL cover: N=M=7, inputs 1,3,5 hold requests on output 2 continuously, i_en[2]=1, no hold -> grants 1,3,5,1,3,5 on consecutive cycles, o_sel[2] follows.
REQ-029 SHALL cover: input 4 requests output 0 with i_en[0]=0 for 5 cycles, then i_en[0]=1 -> no grant for 5 cycles, grant[4][0] one cycle after enable is sampled high.
REQ-030 SHALL cover: input 6 and input 0 request output 3, ptr[3]=6 -> grant 6 first, then 0 (wrap), ptr[3]=1 afterwards.
REQ-031 SHALL cover: inputs 0..6 each request a distinct output in the same cycle -> all seven grants asserted together, one per row/column.
REQ-032 SHALL cover: with ENOC_ALLOC_HOLD_EN, HOLD_MAX=4, inputs 2 and 5 request output 1 continuously -> input 2 granted 4 cycles, 1 idle cycle, input 5 granted 4 cycles.
REQ-033 SHALL cover: reset_n driven low during an active grant -> all o_grant and o_sel_val 0 next cycle, ptr 0, first post-reset winner is lowest requesting index.
